// File: rtl/nv_nvdla_nocif_dram_read_ig_wrr_sched_pkg.sv
// Shared constants for the NOCIF DRAM read ingress scheduler.
// Client count and weight width used as parameter defaults.
package nv_nvdla_nocif_dram_read_ig_wrr_sched_pkg;

    localparam int NVDLA_NUM_DMA_READ_CLIENTS = 10;
    localparam int RD_WT_W                    = 8;

endpackage

// File: rtl/nv_nvdla_nocif_dram_read_ig_wrr_sched_rr_pick.sv
// Rotate-priority picker: first set req bit at or after start, wrapping.
// Shared by the read and write side schedulers.
module nv_nvdla_nocif_rr_pick
    import nv_nvdla_nocif_dram_read_ig_wrr_sched_pkg::*;
#(
    parameter int N     = NVDLA_NUM_DMA_READ_CLIENTS,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     oh,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] j;

    always_comb begin
        oh  = '0;
        idx = '0;
        vld = 1'b0;
        sum = '0;
        j   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, start} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            j = sum[IDX_W-1:0];
            if (!vld && req[j]) begin
                vld   = 1'b1;
                idx   = j;
                oh[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nv_nvdla_nocif_dram_read_ig_wrr_sched.sv
// Weighted round-robin grant scheduler for the DRAM read request channel.
// Owner keeps the channel for wt+1 grants, then ownership rotates.
module nv_nvdla_nocif_dram_read_ig_wrr_sched
    import nv_nvdla_nocif_dram_read_ig_wrr_sched_pkg::*;
#(
    parameter int NUM_CLIENTS = NVDLA_NUM_DMA_READ_CLIENTS,
    parameter int WT_W        = RD_WT_W,
    parameter int IDX_W       = 4
) (
    input  logic                        nvdla_core_clk,
    input  logic                        nvdla_core_rstn,
    input  logic [NUM_CLIENTS-1:0]      req,
    input  logic [NUM_CLIENTS*WT_W-1:0] wt,
    input  logic                        gnt_busy,
    output logic [NUM_CLIENTS-1:0]      gnt,
    output logic                        gnt_vld,
    output logic [IDX_W-1:0]            gnt_idx
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLIENTS-1);
    localparam logic [NUM_CLIENTS-1:0] ONE = NUM_CLIENTS'(1);

    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [WT_W-1:0]  cnt, cnt_nxt;
    logic             own, own_nxt;

    logic [IDX_W-1:0]       start;
    logic [NUM_CLIENTS-1:0] pick_oh;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_vld;
    logic                   cont;
    logic                   take;
    logic [WT_W-1:0]        wt_a [NUM_CLIENTS];

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_wt
        assign wt_a[i] = wt[i*WT_W +: WT_W];
    end

    // Search begins just past the last owner, so it is reconsidered last.
    assign start = (ptr == LAST) ? '0 : ptr + 1'b1;

    nv_nvdla_nocif_rr_pick #(
        .N     (NUM_CLIENTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .start (start),
        .oh    (pick_oh),
        .idx   (pick_idx),
        .vld   (pick_vld)
    );

    assign cont = own & req[ptr] & (cnt != '0);
    assign take = nvdla_core_rstn & ~gnt_busy & (cont | pick_vld);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        if (take) begin
            gnt     = cont ? (ONE << ptr) : pick_oh;
            gnt_idx = cont ? ptr : pick_idx;
        end
    end

    assign gnt_vld = take;

    always_comb begin
        ptr_nxt = ptr;
        cnt_nxt = cnt;
        own_nxt = own;
        if (!gnt_busy) begin
            if (cont) begin
                cnt_nxt = cnt - 1'b1;
            end else if (pick_vld) begin
                ptr_nxt = pick_idx;
                cnt_nxt = wt_a[pick_idx];
                own_nxt = 1'b1;
            end else begin
                own_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            ptr <= LAST;
            cnt <= '0;
            own <= 1'b0;
        end else begin
            ptr <= ptr_nxt;
            cnt <= cnt_nxt;
            own <= own_nxt;
        end
    end

endmodule

// File: tb/tb_nv_nvdla_nocif_dram_read_ig_wrr_sched.sv
// Bench for the read ingress WRR scheduler: directed steps plus random
// traffic against a burst-quota reference model.
module tb_nv_nvdla_nocif_dram_read_ig_wrr_sched;

    localparam int N    = 10;
    localparam int WT_W = 8;
    localparam int IW   = 4;

    logic            clk;
    logic            rstn;
    logic [N-1:0]    req;
    logic [N*WT_W-1:0] wt;
    logic            busy;
    logic [N-1:0]    gnt;
    logic            gnt_vld;
    logic [IW-1:0]   gnt_idx;

    int checks   = 0;
    int failures = 0;

    // Reference: owner, grants used in its burst, burst quota (wt+1).
    int m_own;
    int m_used;
    int m_quota;
    bit m_act;

    nv_nvdla_nocif_dram_read_ig_wrr_sched #(
        .NUM_CLIENTS (N),
        .WT_W        (WT_W),
        .IDX_W       (IW)
    ) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .req             (req),
        .wt              (wt),
        .gnt_busy        (busy),
        .gnt             (gnt),
        .gnt_vld         (gnt_vld),
        .gnt_idx         (gnt_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic bit req_at(int c);
        logic [N-1:0] t;
        t = req >> c;
        return t[0];
    endfunction

    function automatic int wt_of(int c);
        logic [WT_W-1:0] v;
        v = WT_W'(wt >> (c * WT_W));
        return int'(v);
    endfunction

    task automatic set_wt(input int c, input int v);
        wt[c*WT_W +: WT_W] = WT_W'(v);
    endtask

    task automatic m_reset();
        m_own   = N - 1;
        m_used  = 0;
        m_quota = 0;
        m_act   = 0;
    endtask

    task automatic m_eval(output int g, output bit nb);
        g  = -1;
        nb = 0;
        if (!rstn || busy) return;
        if (m_act && req_at(m_own) && m_used < m_quota) begin
            g = m_own;
            return;
        end
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_own + k) % N;
            if (req_at(c)) begin
                g  = c;
                nb = 1;
                return;
            end
        end
    endtask

    // Check one cycle against the model, then advance through the edge.
    task automatic tick(output int oidx, output bit ovld);
        int g;
        bit nb;
        logic [N-1:0] eg;
        #1;
        m_eval(g, nb);
        eg = (g < 0) ? '0 : (N'(1) << g);
        chk("gnt", 32'(gnt), 32'(eg));
        chk("gnt_vld", 32'(gnt_vld), 32'(g >= 0));
        chk("gnt_idx", 32'(gnt_idx), (g < 0) ? 32'd0 : 32'(g));
        oidx = int'(gnt_idx);
        ovld = gnt_vld;
        @(posedge clk);
        if (!busy) begin
            if (g < 0) begin
                m_act = 0;
            end else if (nb) begin
                m_own   = g;
                m_quota = wt_of(g) + 1;
                m_used  = 1;
                m_act   = 1;
            end else begin
                m_used++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        req  = '0;
        busy = 1'b0;
        wt   = '0;
        m_reset();
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_vld", 32'(gnt_vld), 32'd0);
        chk("rst_idx", 32'(gnt_idx), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int  oi;
        bit  ov;
        int  seq2 [8];
        int  run;
        rstn = 1'b0;
        req  = '0;
        busy = 1'b0;
        wt   = '0;
        m_reset();

        // All clients, zero weight: plain round robin from client 0.
        do_reset();
        req = 10'h3FF;
        for (int i = 0; i < 11; i++) begin
            tick(oi, ov);
            chk("t1_seq", 32'(oi), 32'(i % N));
        end

        // Client 0 gets 3 grants per turn, client 1 gets 1.
        do_reset();
        seq2 = '{0, 0, 0, 1, 0, 0, 0, 1};
        set_wt(0, 2);
        set_wt(1, 0);
        req = 10'h003;
        for (int i = 0; i < 8; i++) begin
            tick(oi, ov);
            chk("t2_seq", 32'(oi), 32'(seq2[i]));
        end

        // Busy in mid-burst freezes state.
        do_reset();
        set_wt(0, 3);
        req = 10'h003;
        repeat (2) tick(oi, ov);
        busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(oi, ov);
            chk("t3_busy_vld", 32'(ov), 32'd0);
        end
        busy = 1'b0;
        tick(oi, ov);
        chk("t3_rest0", 32'(oi), 32'd0);
        tick(oi, ov);
        chk("t3_rest1", 32'(oi), 32'd0);
        tick(oi, ov);
        chk("t3_next", 32'(oi), 32'd1);

        // Owner drops request and forfeits its burst.
        do_reset();
        set_wt(2, 5);
        req = 10'h024;
        repeat (2) tick(oi, ov);
        req = 10'h020;
        tick(oi, ov);
        chk("t4_drop", 32'(oi), 32'd5);
        req = 10'h024;
        run = 0;
        for (int i = 0; i < 7; i++) begin
            tick(oi, ov);
            if (oi == 2) run++;
        end
        chk("t4_fresh", 32'(run), 32'd6);
        chk("t4_after", 32'(oi), 32'd5);

        // Sole requester is granted every cycle.
        do_reset();
        set_wt(4, 1);
        req = 10'h010;
        for (int i = 0; i < 8; i++) begin
            tick(oi, ov);
            chk("t5_sole", 32'(oi), 32'd4);
            chk("t5_vld", 32'(ov), 32'd1);
        end

        // Async reset in mid-burst.
        do_reset();
        set_wt(7, 10);
        req = 10'h080;
        repeat (3) tick(oi, ov);
        #2;
        rstn = 1'b0;
        m_reset();
        #1;
        chk("t6_rst_gnt", 32'(gnt), 32'd0);
        chk("t6_rst_vld", 32'(gnt_vld), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        req  = 10'h081;
        tick(oi, ov);
        chk("t6_first", 32'(oi), 32'd0);

        // Random traffic, busy and weight changes.
        do_reset();
        for (int c = 0; c < N; c++) set_wt(c, $urandom_range(0, 3));
        for (int i = 0; i < 500; i++) begin
            req  = N'($urandom) & N'($urandom | $urandom);
            busy = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) begin
                set_wt($urandom_range(0, N - 1), $urandom_range(0, 4));
            end
            tick(oi, ov);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_nocif_dram_read_ig_wrr_sched.md
# nv_nvdla_nocif_dram_read_ig_wrr_sched

Weighted round-robin grant scheduler for the NOCIF DRAM read ingress path. It shares the single read-request channel toward the splitter among up to 16 DMA read clients, each fronted by its own skid pipe. Each client holds the channel for a burst of grants sized by its 8-bit weight, then ownership rotates round-robin. A grant is a completed transfer: it pops the client's pipe and qualifies the channel valid in the same cycle.

## Interface
- NUM_CLIENTS, 10: number of active requesters, 2..16.
- WT_W, 8: weight width per client.
- IDX_W, 4: width of client index; must satisfy 2^IDX_W >= NUM_CLIENTS.
- nvdla_core_clk  in  1  single clock; all state on rising edge.
- nvdla_core_rstn  in  1  asynchronous, active-low reset.
- req  in  NUM_CLIENTS  per-client request, bit i = client i has a head entry valid.
- wt  in  NUM_CLIENTS*WT_W  per-client weight, client i at [i*WT_W +: WT_W]; quasi-static, sampled only at ownership change.
- gnt_busy  in  1  downstream not ready (= !arb2spt_req_ready); suppresses all grants.
- gnt  out  NUM_CLIENTS  one-hot grant, combinational; at most one bit set.
- gnt_vld  out  1  OR of gnt; drives the channel valid.
- gnt_idx  out  IDX_W  encoded index of granted client; 0 when gnt_vld=0.

## Operation
- State: ptr (IDX_W, current or last owner), cnt (WT_W, remaining continuation grants), own (1, owner burst active).
- Reset values: ptr=NUM_CLIENTS-1, cnt=0, own=0. Therefore client 0 is first in search order. Outputs are combinational; with req=0 after reset, gnt=0, gnt_vld=0, gnt_idx=0.
- Grant selection, evaluated each cycle:
  - gnt_busy=1: gnt=0.
  - Else continuation: if own && req[ptr] && cnt!=0, grant ptr.
  - Else new owner: grant the first set req bit scanning ptr+1, ptr+2, … wrapping modulo NUM_CLIENTS and ending at ptr itself.
  - Else no request: gnt=0.
- State update on the clock edge:
  - Continuation grant: cnt <= cnt-1.
  - New-owner grant to w: ptr <= w, cnt <= wt[w], own <= 1. Client w gets wt[w]+1 consecutive grants in total (wt=0 gives 1 grant, wt=255 gives 256).
  - gnt_busy=1: all state holds, including when the owner has dropped req.
  - No grant and gnt_busy=0: own <= 0; ptr and cnt hold. An owner that deasserts req forfeits the rest of its burst.
- Burst exhausted (cnt=0 with own=1): the next grant searches from ptr+1. The old owner is reconsidered last, so it is re-granted only if it is the sole requester; that starts a fresh burst with cnt <= wt[ptr].
- Bits of req at index >= NUM_CLIENTS do not exist. Clients with req tied 0 never win.
- Reset asserted mid-burst: state returns to reset values immediately (async). No grant is output while rstn=0.

## Timing
- Zero-cycle arbitration: gnt follows req, gnt_busy and state combinationally within the same cycle.
- gnt_busy to gnt is a pure combinational path; this is the critical path into the pipe ready. Keep the search to one priority-rotate level.
- Throughput is one grant per cycle when gnt_busy=0.
- wt changes take effect at the next new-owner grant of that client, never mid-burst.

## Structure
- Shared package: NVDLA_NUM_DMA_READ_CLIENTS default and RD_WT_W=8.
- One sub-module, nv_nvdla_nocif_rr_pick: a rotate-priority picker with inputs req and start index, and outputs one-hot and index. It is reused by the write-side scheduler.
- The top holds the ptr/cnt/own registers, the continuation mux and the gnt_busy gating.

## Test plan
- Reset, then req=10'h3FF, all wt=0, gnt_busy=0 -> gnt_idx sequence 0,1,2,…,9,0 with one grant per cycle.
- req=10'h003, wt0=2, wt1=0 -> grant sequence 0,0,0,1,0,0,0,1 (client 0 gets 3 grants per turn, client 1 gets 1).
- Burst on client 0 with wt0=3, gnt_busy=1 held 5 cycles after the second grant -> gnt=0 during busy, state frozen; after release client 0 receives exactly 2 more grants, then client 1.
- Owner drop: wt2=5, client 2 deasserts req after 2 grants while client 5 requests -> next cycle grants 5; client 2 re-requesting later starts a fresh burst of 6.
- Sole requester: req=10'h010, wt4=1 -> client 4 granted every cycle continuously, in bursts of 2 with re-ownership between bursts.
- Async reset asserted mid-burst on client 7 -> gnt=0 immediately. After release with req=10'h081, client 0 is granted first.
